// File: rtl/prime_stream_if.sv
`default_nettype none
// prime_stream_if: valid/ready stream carrying one prime number per transfer.
// Rev 1.0
interface prime_stream_if #(
  parameter int NUM_W = 14
) ();
  logic             prime_valid;
  logic             prime_ready;
  logic [NUM_W-1:0] prime_num;

  modport master (output prime_valid, output prime_num, input prime_ready);
  modport slave  (input prime_valid, input prime_num, output prime_ready);
endinterface
`default_nettype wire

// File: rtl/prime_stream.sv
`default_nettype none
// prime_stream: walks a sieve bitmap from 2 to RANGE, streams each prime and counts them.
// Rev 1.0
module prime_stream #(
  parameter int RANGE = 10000,
  parameter int NUM_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [RANGE-1:0] i_sieve_bits,
  prime_stream_if.master   o_stream,
  output logic [NUM_W-1:0] o_prime_cnt,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [NUM_W-1:0] c_first   = NUM_W'(2);
  localparam logic [NUM_W-1:0] c_last    = NUM_W'(RANGE);
  localparam logic [NUM_W-1:0] c_cnt_max = '1;

  state_t           r_state;
  logic [NUM_W-1:0] r_idx;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_done;

  logic [RANGE-1:0] w_shifted;
  logic             w_is_prime;
  logic             w_at_end;
  logic             w_accept;

  // Bit idx-1 represents number idx; the bitmap is read live every cycle.
  assign w_shifted  = i_sieve_bits >> (r_idx - 1'b1);
  assign w_is_prime = w_shifted[0];
  assign w_at_end   = (r_idx == c_last);
  assign w_accept   = r_valid & o_stream.prime_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= c_first;
      r_num   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_SCAN;
            r_idx   <= c_first;
            r_cnt   <= '0;
          end
        end
        S_SCAN: begin
          if (w_is_prime) begin
            r_num   <= r_idx;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end else if (w_at_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_OUT: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_at_end) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stream.prime_valid = r_valid;
  assign o_stream.prime_num   = r_num;
  assign o_prime_cnt          = r_cnt;
  assign o_done               = r_done;
  assign o_busy               = (r_state == S_SCAN) || (r_state == S_OUT);

endmodule
`default_nettype wire
